// File: rtl/board_engine_m.sv
// N x N, K-in-a-row board: handshaked moves, then a one-cell-per-cycle win/draw scan.
// Define UNDO_EN to add a move-history LIFO with an undo request.
module board_engine_m #(
  parameter int N = 3,
  parameter int K = 3,
  localparam int IW = $clog2(N * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     move_loc,
  input  logic              move_valid,
  output logic              move_ready,
  output logic              move_reject,
  input  logic              undo,
  output logic [2*N*N-1:0]  board_state,
  output logic              turn,
  output logic              refresh,
  output logic              game_over,
  output logic [1:0]        winner
);

  localparam int CELLS = N * N;
  localparam int MCW   = $clog2(N * N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  logic [1:0]       state;
  logic [2*CELLS-1:0] board;
  logic [IW-1:0]    scan_r;
  logic [IW-1:0]    scan_c;
  logic [MCW-1:0]   move_count;
  logic [1:0]       mark;
  logic [1:0]       cur_cell;
  logic             in_range;
  logic             legal;
  logic             accept;
  logic             reject_now;
  logic             scan_last;
  logic             hit;
  logic             undo_take;

  assign board_state = board;
  assign move_ready  = (state == S_IDLE);
  assign mark        = turn ? 2'b10 : 2'b01;
  assign in_range    = {1'b0, move_loc} < (IW+1)'(CELLS);
  assign cur_cell    = board[{move_loc, 1'b0} +: 2];
  assign legal       = in_range && (cur_cell == 2'b00);
  assign accept      = (state == S_IDLE) && move_valid && !undo_take && legal;
  assign reject_now  = (state == S_IDLE) && move_valid && !undo_take && !legal;
  assign scan_last   = (scan_r == IW'(N - 1)) && (scan_c == IW'(N - 1));

  // Runs start at the scanned cell; edge-crossing runs are disqualified before any read matters.
  always_comb begin
    int   base;
    int   step;
    logic ok;
    logic all_match;
    hit       = 1'b0;
    step      = 1;
    ok        = 1'b0;
    all_match = 1'b0;
    base      = int'(scan_r) * N + int'(scan_c);
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin step = 1;     ok = (int'(scan_c) + K <= N); end
        1:       begin step = N;     ok = (int'(scan_r) + K <= N); end
        2:       begin step = N + 1; ok = (int'(scan_c) + K <= N) && (int'(scan_r) + K <= N); end
        default: begin step = N - 1; ok = (int'(scan_c) >= K - 1) && (int'(scan_r) + K <= N); end
      endcase
      all_match = ok;
      for (int j = 0; j < K; j++) begin
        if (board[{IW'(base + j * step), 1'b0} +: 2] != mark) all_match = 1'b0;
      end
      if (all_match) hit = 1'b1;
    end
  end

`ifdef UNDO_EN
  logic [IW-1:0] hist [CELLS];
  logic [IW-1:0] pop_loc;
  logic [1:0]    pop_mark;

  assign undo_take = undo && (move_count != '0) && (state != S_SCAN);
  assign pop_loc   = hist[IW'(move_count - 1'b1)];
  assign pop_mark  = board[{pop_loc, 1'b0} +: 2];

  // move_count doubles as the LIFO depth.
  always_ff @(posedge clk) begin
    if (accept) hist[IW'(move_count)] <= move_loc;
  end
`else
  logic unused_undo;
  assign unused_undo = undo;
  assign undo_take   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      board       <= '0;
      turn        <= 1'b0;
      move_count  <= '0;
      scan_r      <= '0;
      scan_c      <= '0;
      move_reject <= 1'b0;
      refresh     <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
    end else begin
      move_reject <= reject_now;
      refresh     <= accept | undo_take;
      case (state)
        S_IDLE: begin
          if (accept) begin
            board[{move_loc, 1'b0} +: 2] <= mark;
            move_count <= move_count + 1'b1;
            scan_r     <= '0;
            scan_c     <= '0;
            state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (hit) begin
            game_over <= 1'b1;
            winner    <= mark;
            state     <= S_OVER;
          end else if (scan_last) begin
            if (move_count == MCW'(CELLS)) begin
              game_over <= 1'b1;
              winner    <= 2'b00;
              state     <= S_OVER;
            end else begin
              turn  <= ~turn;
              state <= S_IDLE;
            end
          end else if (scan_c == IW'(N - 1)) begin
            scan_c <= '0;
            scan_r <= scan_r + 1'b1;
          end else begin
            scan_c <= scan_c + 1'b1;
          end
        end
        default: ;
      endcase
`ifdef UNDO_EN
      // The popped cell's owner moves next, which also holds after a game-ending move.
      if (undo_take) begin
        board[{pop_loc, 1'b0} +: 2] <= 2'b00;
        move_count <= move_count - 1'b1;
        turn       <= pop_mark[1];
        game_over  <= 1'b0;
        winner     <= 2'b00;
        state      <= S_IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_board_engine_m.sv
// Bench: 3x3/K=3 and 4x4/K=3 boards against a cell-array game model.
module tb_board_engine_m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  loc0 = '0;
  logic [3:0]  loc1 = '0;
  logic [1:0]  val = '0;
  logic [1:0]  und = '0;
  logic [1:0]  rdy, rej, trn, rfs, go;
  logic [1:0]  w0, w1;
  logic [17:0] bs3;
  logic [31:0] bs4;

  always #5 clk = ~clk;

  board_engine_m #(.N(3), .K(3)) u3 (
    .clk(clk), .reset(rst), .move_loc(loc0), .move_valid(val[0]), .move_ready(rdy[0]),
    .move_reject(rej[0]), .undo(und[0]), .board_state(bs3), .turn(trn[0]),
    .refresh(rfs[0]), .game_over(go[0]), .winner(w0)
  );

  board_engine_m #(.N(4), .K(3)) u4 (
    .clk(clk), .reset(rst), .move_loc(loc1), .move_valid(val[1]), .move_ready(rdy[1]),
    .move_reject(rej[1]), .undo(und[1]), .board_state(bs4), .turn(trn[1]),
    .refresh(rfs[1]), .game_over(go[1]), .winner(w1)
  );

  int errors = 0;
  int checks = 0;
  int mb [2][16];
  int mturn [2];
  int mgo [2];
  int mwin [2];
  int mcnt [2];
  int hist0 [$];
  int hist1 [$];
  bit settled [2];
  bit erej [2];
  bit eref [2];
  bit chk_on = 1'b0;

  function automatic int nn(int i);
    return (i == 0) ? 3 : 4;
  endfunction

  function automatic logic [31:0] mpack(int i);
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < nn(i) * nn(i); c++) v[2*c +: 2] = 2'(mb[i][c]);
    return v;
  endfunction

  function automatic logic [31:0] dbs(int i);
    return (i == 0) ? {14'b0, bs3} : bs4;
  endfunction

  // K=3 line of equal marks anywhere on the board, walking direction vectors with bounds.
  function automatic bit won(int i, int m);
    int n, rr, cc;
    bit ok;
    int dr [4] = '{0, 1, 1, 1};
    int dc [4] = '{1, 0, 1, -1};
    n = nn(i);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          ok = 1'b1;
          for (int j = 0; j < 3; j++) begin
            rr = r + j * dr[d];
            cc = c + j * dc[d];
            if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
            else if (mb[i][rr*n+cc] != m) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic chk(int i, string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0h expected %0h at %0t", i, nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk(i, "board", dbs(i), mpack(i));
        chk(i, "reject", 32'(rej[i]), 32'(erej[i]));
        chk(i, "refresh", 32'(rfs[i]), 32'(eref[i]));
        if (settled[i]) begin
          chk(i, "turn", 32'(trn[i]), 32'(mturn[i]));
          chk(i, "game_over", 32'(go[i]), 32'(mgo[i]));
          chk(i, "winner", (i == 0) ? 32'(w0) : 32'(w1), 32'(mwin[i]));
          chk(i, "ready", 32'(rdy[i]), (mgo[i] != 0) ? 32'd0 : 32'd1);
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 16; c++) mb[i][c] = 0;
      mturn[i] = 0; mgo[i] = 0; mwin[i] = 0; mcnt[i] = 0;
      settled[i] = 1'b1; erej[i] = 1'b0; eref[i] = 1'b0;
    end
    hist0.delete();
    hist1.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; val = '0; und = '0;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_loc(int i, int v);
    if (i == 0) loc0 = 4'(v);
    else        loc1 = 4'(v);
  endtask

  task automatic move(int i, int loc, bit wait_scan);
    int n, cyc;
    bit legal;
    n = nn(i);
    legal = (loc < n * n) && (mb[i][loc] == 0);
    @(posedge clk); #1;
    set_loc(i, loc); val[i] = 1'b1;
    @(posedge clk); #1;
    val[i] = 1'b0;
    if (!legal) erej[i] = 1'b1;
    else begin
      mb[i][loc] = mturn[i] + 1;
      mcnt[i]++;
      if (i == 0) hist0.push_back(loc); else hist1.push_back(loc);
      eref[i] = 1'b1;
      settled[i] = 1'b0;
    end
    @(posedge clk); #1;
    erej[i] = 1'b0; eref[i] = 1'b0;
    if (legal && wait_scan) begin
      cyc = 1;
      while (!(rdy[i] || go[i]) && cyc < n * n + 1) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk(i, "latency", 32'(rdy[i] | go[i]), 32'd1);
      if (won(i, mturn[i] + 1)) begin mgo[i] = 1; mwin[i] = mturn[i] + 1; end
      else if (mcnt[i] == n * n) begin mgo[i] = 1; mwin[i] = 0; end
      else mturn[i] = 1 - mturn[i];
      settled[i] = 1'b1;
    end
  endtask

  task automatic ignore_moves(int i, int loc, int cycles);
    @(posedge clk); #1;
    set_loc(i, loc); val[i] = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 val[i] = 1'b0;
  endtask

`ifdef UNDO_EN
  task automatic do_undo(int i);
    int p;
    bit take;
    take = (i == 0) ? (hist0.size() > 0) : (hist1.size() > 0);
    @(posedge clk); #1;
    und[i] = 1'b1;
    @(posedge clk); #1;
    und[i] = 1'b0;
    if (take) begin
      p = (i == 0) ? hist0.pop_back() : hist1.pop_back();
      mturn[i] = mb[i][p] - 1;
      mb[i][p] = 0;
      mcnt[i]--;
      mgo[i] = 0; mwin[i] = 0;
      eref[i] = 1'b1;
    end
    @(posedge clk); #1;
    eref[i] = 1'b0;
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seq_win [5]  = '{0, 3, 1, 4, 2};
    int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_diag [5] = '{1, 0, 6, 4, 11};
    int seq_wrap [5] = '{2, 8, 3, 12, 4};
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk(0, "rst_ready", 32'(rdy), 32'b11);
    chk(0, "rst_board3", 32'(bs3), 32'd0);
    chk(1, "rst_board4", bs4, 32'd0);
    chk(0, "rst_outs", {26'b0, go, rej, rfs}, 32'd0);
    chk(0, "rst_turn_win", {28'b0, w0, trn}, 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Row 0 win for X, then moves are ignored.
    foreach (seq_win[k]) move(0, seq_win[k], 1'b1);
    chk(0, "lit_win_board", 32'(bs3), 32'h295);
    chk(0, "lit_win", 32'(w0), 32'd1);
    chk(0, "model_win", 32'(mwin[0]), 32'd1);
    ignore_moves(0, 5, 4);
    chk(0, "lit_after_over", 32'(bs3), 32'h295);

    do_reset();
    move(0, 4, 1'b1);
    move(0, 4, 1'b1);
    chk(0, "lit_cell4", 32'(bs3[9:8]), 32'd1);
    chk(0, "lit_turn", 32'(trn[0]), 32'd1);
    move(0, 9, 1'b1);
    chk(0, "lit_oob_board", 32'(bs3), 32'h100);

    do_reset();
    foreach (seq_draw[k]) move(0, seq_draw[k], 1'b1);
    chk(0, "lit_draw_over", 32'(go[0]), 32'd1);
    chk(0, "lit_draw_win", 32'(w0), 32'd0);
    chk(0, "model_draw", 32'(mgo[0] * 4 + mwin[0]), 32'd4);

    do_reset();
    foreach (seq_diag[k]) move(1, seq_diag[k], 1'b1);
    chk(1, "lit_diag_win", 32'(w1), 32'd1);

    do_reset();
    foreach (seq_wrap[k]) move(1, seq_wrap[k], 1'b1);
    chk(1, "lit_wrap_over", 32'(go[1]), 32'd0);
    chk(1, "lit_wrap_turn", 32'(trn[1]), 32'd1);
    chk(1, "model_wrap", 32'(mgo[1]), 32'd0);

    // Reset lands while the scan is in progress.
    do_reset();
    move(0, 4, 1'b0);
    repeat (2) @(posedge clk);
    do_reset();
    chk(0, "lit_midscan_board", 32'(bs3), 32'd0);
    chk(0, "lit_midscan_ready", 32'(rdy[0]), 32'd1);

`ifdef UNDO_EN
    do_reset();
    do_undo(0);
    chk(0, "lit_undo_empty", 32'(bs3), 32'd0);
    move(0, 0, 1'b1);
    move(0, 1, 1'b1);
    do_undo(0);
    chk(0, "lit_undo_cell1", 32'(bs3[3:2]), 32'd0);
    chk(0, "lit_undo_turn", 32'(trn[0]), 32'd1);
`endif

    for (int g = 0; g < 8; g++) begin
      do_reset();
      for (int s = 0; s < 40; s++) begin
        if (mgo[g % 2] != 0) break;
        move(g % 2, $urandom_range(0, 15), 1'b1);
      end
    end

    repeat (2) @(posedge clk);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
